// File: rtl/keypad_pkg.sv
// Shared keypad geometry, FSM state type and column-drive helpers.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);
  localparam int KEY_W    = ROW_W + COL_W;

  // Column 0 driven low out of reset
  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } kp_state_e;

  // Active-low one-hot drive pattern for a column index
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] idx);
    col_drive = ~(NUM_COLS'(1) << idx);
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and host-side signals of the scanner.
// master: the scanner itself; slave: keypad matrix / consumer of key events.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_in;
  logic [NUM_COLS-1:0] col_out;
  logic [KEY_W-1:0]    key_code;
  logic                key_valid;
  logic                key_held;

  modport master (input row_in, output col_out, key_code, key_valid, key_held);
  modport slave  (output row_in, input col_out, key_code, key_valid, key_held);
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider: tick is high on the last cycle of each DIV-cycle slot.
module scan_tick_gen #(
  parameter int DIV = 27000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..DIV-1 and wrap; never stalls regardless of scanner state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe once per
// slot, debounces press and release on slot ticks, reports the key as row*4+col.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 27000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  bus
);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic                tick;
  logic [NUM_ROWS-1:0] row_s1, row_s2;
  kp_state_e           state_q, nxt_state;
  logic [COL_W-1:0]    col_q, nxt_col;
  logic [ROW_W-1:0]    row_q, nxt_row;
  logic [CNT_W-1:0]    press_q, nxt_press, rel_q, nxt_rel;
  logic [NUM_COLS-1:0] col_out_q;
  logic [KEY_W-1:0]    key_code_q;
  logic                key_valid_q, key_held_q;
  logic                accept, rel_done;
  logic                low_any;
  logic [ROW_W-1:0]    low_idx;

  scan_tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchronizer; idle rows read as high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= bus.row_in;
      row_s2 <= row_s1;
    end
  end

  // Lowest-numbered low row wins when several are pressed in one column
  always_comb begin
    low_any = ~&row_s2;
    low_idx = '0;
    for (int r = NUM_ROWS - 1; r >= 0; r--)
      if (!row_s2[r]) low_idx = ROW_W'(r);
  end

  // Next-state: every decision is taken on a tick, rows between ticks ignored
  always_comb begin
    nxt_state = state_q;
    nxt_col   = col_q;
    nxt_row   = row_q;
    nxt_press = press_q;
    nxt_rel   = rel_q;
    accept    = 1'b0;
    rel_done  = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (low_any) begin
            nxt_row = low_idx;
            if (DEBOUNCE_SCANS == 1) begin
              accept    = 1'b1;
              nxt_state = HELD;
              nxt_press = '0;
              nxt_rel   = '0;
            end else begin
              nxt_press = CNT_W'(1);
              nxt_state = DEBOUNCE;
            end
          end else begin
            nxt_col = col_q + COL_W'(1);
          end
        end
        DEBOUNCE: begin
          if (!row_s2[row_q]) begin
            if (press_q + CNT_W'(1) == DB_MAX) begin
              accept    = 1'b1;
              nxt_state = HELD;
              nxt_press = '0;
              nxt_rel   = '0;
            end else begin
              nxt_press = press_q + CNT_W'(1);
            end
          end else begin
            nxt_state = SCAN;
            nxt_press = '0;
            nxt_col   = col_q + COL_W'(1);
          end
        end
        HELD: begin
          if (row_s2[row_q]) begin
            if (rel_q + CNT_W'(1) == DB_MAX) begin
              rel_done  = 1'b1;
              nxt_state = SCAN;
              nxt_rel   = '0;
              nxt_col   = col_q + COL_W'(1);
            end else begin
              nxt_rel = rel_q + CNT_W'(1);
            end
          end else begin
            nxt_rel = '0;
          end
        end
        default: nxt_state = SCAN;
      endcase
    end
  end

  // FSM state, latched column/row and debounce counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SCAN;
      col_q     <= '0;
      row_q     <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      col_out_q <= COL_RESET;
    end else begin
      state_q   <= nxt_state;
      col_q     <= nxt_col;
      row_q     <= nxt_row;
      press_q   <= nxt_press;
      rel_q     <= nxt_rel;
      col_out_q <= col_drive(nxt_col);
    end
  end

  // Key event outputs, all updated on the edge closing the accepting tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= accept;
      if (accept) begin
        key_code_q <= {nxt_row, col_q};
        key_held_q <= 1'b1;
      end else if (rel_done) begin
        key_held_q <= 1'b0;
      end
    end
  end

  assign bus.col_out   = col_out_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.key_held  = key_held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: a physical keypad model drives rows from the pressed
// key set and the live column strobe; a behavioural model predicts all outputs.
module tb_keypad_scanner;
  localparam int DIV = 4;
  localparam int DB  = 2;
  localparam int M_IDLE = 0, M_CONF = 1, M_HOLD = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;

  keypad_scanner_if bus ();

  keypad_scanner #(.SCAN_DIV(DIV), .DEBOUNCE_SCANS(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0, vld_seen = 0;
  logic [15:0] pressed;

  // reference model state
  int m_ph, m_col, m_mode, m_row, m_hits, m_miss, m_code;
  bit m_valid, m_held;
  logic [3:0] m_q1, m_q2;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [3:0] keypad_rows(logic [15:0] keys, logic [3:0] cols);
    logic [3:0] r;
    r = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys[k] && !cols[k % 4]) r[k / 4] = 1'b0;
    return r;
  endfunction

  task automatic model_init();
    m_ph = 0; m_col = 0; m_mode = M_IDLE; m_row = 0;
    m_hits = 0; m_miss = 0; m_code = 0; m_valid = 0; m_held = 0;
    m_q1 = 4'hF; m_q2 = 4'hF;
  endtask

  // One clock of the reference: rows seen at a tick are those sampled two clocks earlier
  task automatic model_step(logic [3:0] rin);
    bit tick;
    logic [3:0] rows;
    tick = (m_ph == DIV - 1);
    rows = m_q2;
    m_valid = 0;
    if (tick) begin
      if (m_mode == M_IDLE) begin
        if (rows != 4'hF) begin
          m_row = 0;
          while (rows[m_row]) m_row++;
          m_hits = 1;
          m_mode = M_CONF;
        end else m_col = (m_col + 1) % 4;
      end else if (m_mode == M_CONF) begin
        if (!rows[m_row]) m_hits++;
        else begin m_mode = M_IDLE; m_hits = 0; m_col = (m_col + 1) % 4; end
      end else begin
        if (rows[m_row]) m_miss++; else m_miss = 0;
        if (m_miss == DB) begin
          m_mode = M_IDLE; m_held = 0; m_miss = 0; m_col = (m_col + 1) % 4;
        end
      end
      if (m_mode == M_CONF && m_hits == DB) begin
        m_mode = M_HOLD; m_valid = 1; m_held = 1;
        m_code = m_row * 4 + m_col; m_miss = 0; m_hits = 0;
      end
    end
    m_ph = (m_ph + 1) % DIV;
    m_q2 = m_q1;
    m_q1 = rin;
  endtask

  // Called at a falling edge: compare, drive rows, advance model, wait one clock
  task automatic cycle();
    logic [3:0] exp_col;
    exp_col = 4'hF;
    exp_col[m_col] = 1'b0;
    chk("col_out", int'(bus.col_out), int'(exp_col));
    chk("key_code", int'(bus.key_code), m_code);
    chk("key_valid", int'(bus.key_valid), int'(m_valid));
    chk("key_held", int'(bus.key_held), int'(m_held));
    if (bus.key_valid) vld_seen++;
    bus.row_in = keypad_rows(pressed, bus.col_out);
    model_step(bus.row_in);
    @(negedge clk);
  endtask

  task automatic run_until(string tag, int want, int budget);
    int n;
    n = 0;
    while (m_mode != want && n < budget) begin cycle(); n++; end
    chk({tag, "_reach"}, int'(m_mode == want), 1);
    chk({tag, "_held"}, int'(bus.key_held), int'(want == M_HOLD));
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_col"}, int'(bus.col_out), 14);
    chk({tag, "_code"}, int'(bus.key_code), 0);
    chk({tag, "_valid"}, int'(bus.key_valid), 0);
    chk({tag, "_held"}, int'(bus.key_held), 0);
  endtask

  // Asynchronous reset in the low clock phase, outputs checked before any edge
  task automatic do_reset();
    pressed = '0;
    bus.row_in = 4'hF;
    #2 reset = 1'b0;
    #1 chk_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_init();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n, hold, gap;
    logic [15:0] keys;
    pressed = '0;
    bus.row_in = 4'hF;
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b1;
    model_init();

    // idle rotation, each column for a full slot
    base = vld_seen;
    repeat (48) cycle();
    chk("idle_vld", vld_seen - base, 0);

    // steady press row1/col2, release bounce, then real release
    base = vld_seen;
    pressed = 16'h0040;
    run_until("press6", M_HOLD, 200);
    chk("press6_code", int'(bus.key_code), 6);
    chk("press6_col", int'(bus.col_out), 4'b1011);
    repeat (12) cycle();
    pressed = '0;
    n = 0;
    while (m_miss != 1 && n < 20) begin cycle(); n++; end
    chk("bounce_reach", int'(m_miss == 1), 1);
    pressed = 16'h0040;
    repeat (12) cycle();
    chk("bounce_held", int'(bus.key_held), 1);
    pressed = '0;
    run_until("release6", M_IDLE, 40);
    chk("press6_pulses", vld_seen - base, 1);
    chk("code_kept", int'(bus.key_code), 6);

    // single-tick glitch on row1/col2
    base = vld_seen;
    pressed = 16'h0040;
    run_until("glitch_det", M_CONF, 100);
    pressed = '0;
    run_until("glitch_back", M_IDLE, 20);
    chk("glitch_col", int'(bus.col_out), 4'b0111);
    chk("glitch_vld", vld_seen - base, 0);

    // two rows in col0: lowest row wins; then row2/col3 alone
    pressed = 16'h1001;
    run_until("multi", M_HOLD, 200);
    chk("multi_code", int'(bus.key_code), 0);
    pressed = '0;
    run_until("multi_rel", M_IDLE, 40);
    pressed = 16'h0800;
    run_until("key11", M_HOLD, 200);
    chk("key11_code", int'(bus.key_code), 11);
    pressed = '0;
    run_until("key11_rel", M_IDLE, 40);

    // random episodes with contact chatter
    for (int ep = 0; ep < 30; ep++) begin
      keys = '0;
      keys[$urandom_range(15, 0)] = 1'b1;
      if ($urandom_range(3, 0) == 0) keys[$urandom_range(15, 0)] = 1'b1;
      hold = $urandom_range(70, 0);
      gap = $urandom_range(40, 0);
      for (int i = 0; i < hold; i++) begin
        pressed = ($urandom_range(9, 0) == 0) ? 16'h0000 : keys;
        cycle();
      end
      pressed = '0;
      for (int i = 0; i < gap; i++) cycle();
    end

    // reset while held: pending key dropped, scanning restarts at col0
    pressed = 16'h0020;
    run_until("pre_rst", M_HOLD, 200);
    base = vld_seen;
    do_reset();
    repeat (24) cycle();
    chk("rst_vld", vld_seen - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SCAN_DIV, default 27000: clock cycles per column slot (1 ms at 27 MHz); SHALL be at least 4.
REQ-002 DEBOUNCE_SCANS, default 4: consecutive matching scan ticks needed to accept a press or a release; range 1..15.
REQ-003 clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 row_in  in  4  keypad rows, active-low with external pull-ups; asynchronous to clk.
REQ-006 col_out  out  4  column drive, active-low one-hot: exactly one bit low at all times.
REQ-007 key_code  out  4  last accepted key, encoded as row*4+col.
REQ-008 key_valid  out  1  one-cycle pulse when a press is accepted.
REQ-009 key_held  out  1  high while the accepted key is still considered pressed.

Function
REQ-010 row_in SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value only.
REQ-011 A free-running tick counter SHALL count 0..SCAN_DIV-1 and wrap; tick is the cycle with count == SCAN_DIV-1. The counter runs in every state.
REQ-012 FSM states SHALL be SCAN, DEBOUNCE and HELD.
REQ-013 SCAN, tick, all rows high: col_out SHALL rotate col0->col1->col2->col3->col0 (1110->1101->1011->0111->1110).
REQ-014 SCAN, tick, any row low: latch col index and lowest-numbered low row, set press count = 1, enter DEBOUNCE, freeze col_out.
REQ-015 DEBOUNCE, tick, latched row low: press count +1. When the count reaches DEBOUNCE_SCANS, pulse key_valid, update key_code and enter HELD.
REQ-016 DEBOUNCE, tick, latched row high (a different row low also counts as high): return to SCAN, clear count, advance col_out to the next column.
REQ-017 If DEBOUNCE_SCANS == 1, the detecting tick in SCAN SHALL accept directly and go to HELD.
REQ-018 key_valid SHALL be high for exactly one cycle: the cycle after the accepting tick. key_code and key_held SHALL update on that same edge.
REQ-019 HELD: key_held = 1 and col_out stays frozen. Each tick with the latched row high increments the release count; a tick with it low clears the count. When the count reaches DEBOUNCE_SCANS: key_held = 0, enter SCAN, advance the column.
REQ-020 Row changes between ticks SHALL have no effect; only tick samples count.
REQ-021 key_code SHALL hold its value until the next accepted press; key_valid SHALL never reassert during one HELD episode.
REQ-022 Multiple rows low in the same column: the lowest row index SHALL win. Keys in other columns are invisible while col_out is frozen.

Reset
REQ-023 While reset = 0 (asynchronously): state = SCAN, col_out = 1110, key_code = 0, key_valid = 0, key_held = 0, and the tick, press and release counters and synchronizer flops all cleared (synchronizer to all-ones).
REQ-024 Reset asserted in DEBOUNCE or HELD SHALL discard the pending key with no key_valid pulse. After release, scanning SHALL restart at col0 with a full SCAN_DIV slot.

Structure
REQ-025 Package keypad_pkg SHALL hold NUM_ROWS = 4, NUM_COLS = 4, the state enumeration, and the col_out reset value 1110.
REQ-026 The tick divider SHALL be a sub-module scan_tick_gen (parameter DIV, output tick). The FSM, synchronizer and encoder stay in keypad_scanner.
REQ-027 Counter widths SHALL be derived from the parameters via clog2; no magic widths.

Verification (bench: SCAN_DIV = 4, DEBOUNCE_SCANS = 2, keypad model drives row_in low only when the pressed key's column is driven low)
REQ-028 After reset release, no key: col_out cycles 1110, 1101, 1011, 0111, each for 4 cycles, repeating; key_valid never high.
REQ-029 Press row1/col2 steadily: exactly one key_valid pulse with key_code = 6, 1 cycle after the second matching tick; key_held = 1; col_out held at 1011.
REQ-030 Row1/col2 low only on the detecting tick, high on the next tick: no key_valid; scanning resumes at 0111.
REQ-031 Release after 3 held ticks: key_held falls 1 cycle after the second consecutive high tick. A single high tick followed by low keeps key_held = 1.
REQ-032 Rows 0 and 3 pressed in col0 together: key_code = 0. Then press row2/col3 alone: key_code = 11.
REQ-033 Reset pulsed while in HELD: all outputs at reset values immediately; no key_valid; col_out = 1110 and restarts at col0.
